// File: rtl/counter_mod8_sched_pkg.sv
// Shared definitions for the mod-8 counter scheduler: state encoding, widths
// and a small wrap helper used by the round-robin selector.
package counter_sched_pkg;

  localparam int COUNT_W  = 3;
  localparam int MAX_SLOT = 8;
  localparam int MAX_REQ  = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int nreq);
    int r;
    r = base % nreq;
    return IDX_W'(r);
  endfunction

endpackage

// File: rtl/counter_mod8_sched_if.sv
// Bundle between requesting control blocks (master) and the scheduler (slave).
interface counter_mod8_sched_if
  import counter_sched_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    grant;
  logic               cnt_en;
  logic [COUNT_W-1:0] count;
  logic               busy;
  logic               slot_done;

  modport master (
    output req,
    input  grant, cnt_en, count, busy, slot_done
  );

  modport slave (
    input  req,
    output grant, cnt_en, count, busy, slot_done
  );

endinterface

// File: rtl/counter_mod8_sched_rr_pick.sv
// Combinational round-robin selector: the first requester found scanning
// upward from last+1 (mod NREQ) wins.
module rr_pick
  import counter_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_cand [NREQ];
  logic [NREQ-1:0]  w_hit;

  // Candidate gi is the requester at priority position gi after the last owner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign w_cand[gi] = wrap_idx(int'(i_last) + gi + 1, NREQ);
    assign w_hit[gi]  = i_req[w_cand[gi]];
  end

  always_comb begin
    o_idx    = '0;
    o_valid  = 1'b0;
    o_onehot = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_idx   = w_cand[k];
        o_valid = 1'b1;
      end
    end
    if (o_valid) begin
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/counter_mod8_sched.sv
// Round-robin scheduler granting one shared mod-8 counter to one of NREQ
// requesters for a slot of SLOT_LEN counts, with a one-cycle release gap.
module counter_mod8_sched
  import counter_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SLOT_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_mod8_sched_if.slave  bus
);

  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(SLOT_LEN - 1);

  state_t             r_state;
  logic [NREQ-1:0]    r_grant;
  logic               r_cnt_en;
  logic [COUNT_W-1:0] r_count;
  logic               r_busy;
  logic               r_slot_done;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_owner;

  logic [NREQ-1:0]    w_onehot;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic               w_owner_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  assign w_owner_req = bus.req[r_owner];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_cnt_en    <= 1'b0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_slot_done <= 1'b0;
      r_last      <= IDX_W'(NREQ - 1);
      r_owner     <= '0;
    end else begin
      case (r_state)
        IDLE, RELEASE: begin
          r_slot_done <= 1'b0;
          r_count     <= '0;
          if (w_valid) begin
            r_state  <= GRANT;
            r_grant  <= w_onehot;
            r_owner  <= w_idx;
            r_cnt_en <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_cnt_en <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        GRANT: begin
          // Owner dropping its request ends the slot early without slot_done.
          if (!w_owner_req || (r_count == LAST_CNT)) begin
            r_state     <= RELEASE;
            r_grant     <= '0;
            r_cnt_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_count     <= '0;
            r_last      <= r_owner;
            r_slot_done <= w_owner_req;
          end else begin
            r_count <= r_count + COUNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_grant     <= '0;
          r_cnt_en    <= 1'b0;
          r_busy      <= 1'b0;
          r_count     <= '0;
          r_slot_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = r_grant;
  assign bus.cnt_en    = r_cnt_en;
  assign bus.count     = r_count;
  assign bus.busy      = r_busy;
  assign bus.slot_done = r_slot_done;

endmodule

// File: tb/tb_counter_mod8_sched.sv
// Directed self-checking bench for counter_mod8_sched (SLOT_LEN 8 and 3).
module tb_counter_mod8_sched;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  counter_mod8_sched_if #(.NREQ(4)) bus  ();
  counter_mod8_sched_if #(.NREQ(4)) bus3 ();

  counter_mod8_sched #(.NREQ(4), .SLOT_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  counter_mod8_sched #(.NREQ(4), .SLOT_LEN(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    bus.req  = '0;
    bus3.req = '0;
    #3;
    n_cmp++;
    if ({bus.grant, bus.cnt_en, bus.count, bus.busy, bus.slot_done} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got grant=%b en=%b cnt=%0d busy=%b done=%b want all 0",
               bus.grant, bus.cnt_en, bus.count, bus.busy, bus.slot_done);
    end
    #3 reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: got grant=%b busy=%b want 0000/0", bus.grant, bus.busy);
    end
    $display("test_reset done: grant=%b", bus.grant);
  endtask

  task automatic test_single();
    bus.req = 4'b0001;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (bus.grant !== 4'b0001 || bus.cnt_en !== 1'b1 || bus.busy !== 1'b1 ||
          bus.count !== 3'(i) || bus.slot_done !== 1'b0) begin
        n_bad++;
        $display("FAIL single_slot[%0d]: got grant=%b en=%b busy=%b cnt=%0d done=%b want 0001/1/1/%0d/0",
                 i, bus.grant, bus.cnt_en, bus.busy, bus.count, bus.slot_done, i);
      end
      tick();
    end
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.cnt_en !== 1'b0 || bus.slot_done !== 1'b1 || bus.count !== 3'd0) begin
      n_bad++;
      $display("FAIL single_release: got grant=%b en=%b done=%b cnt=%0d want 0000/0/1/0",
               bus.grant, bus.cnt_en, bus.slot_done, bus.count);
    end
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0001 || bus.count !== 3'd0 || bus.slot_done !== 1'b0) begin
      n_bad++;
      $display("FAIL single_regrant: got grant=%b cnt=%0d done=%b want 0001/0/0",
               bus.grant, bus.count, bus.slot_done);
    end
    bus.req = 4'b0000;
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.slot_done !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drop: got grant=%b done=%b want 0000/0", bus.grant, bus.slot_done);
    end
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_idle: got busy=%b grant=%b want 0/0000", bus.busy, bus.grant);
    end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    int         done_cnt;
    do_reset();
    done_cnt = 0;
    bus.req  = 4'b1111;
    tick();
    for (int s = 0; s < 4; s++) begin
      exp_g = 4'b0001 << s;
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (bus.grant !== exp_g || bus.cnt_en !== 1'b1 || bus.count !== 3'(i)) begin
          n_bad++;
          $display("FAIL rr_slot[%0d][%0d]: got grant=%b en=%b cnt=%0d want %b/1/%0d",
                   s, i, bus.grant, bus.cnt_en, bus.count, exp_g, i);
        end
        tick();
      end
      if (bus.slot_done === 1'b1) done_cnt++;
      n_cmp++;
      if (bus.grant !== 4'b0000 || bus.cnt_en !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_gap[%0d]: got grant=%b en=%b want 0000/0", s, bus.grant, bus.cnt_en);
      end
      tick();
    end
    n_cmp++;
    if (done_cnt !== 4) begin
      n_bad++;
      $display("FAIL rr_done_count: got %0d want 4", done_cnt);
    end
    n_cmp++;
    if (bus.grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL rr_wrap: got grant=%b want 0001", bus.grant);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    $display("test_back_to_back done: slot_done pulses=%0d", done_cnt);
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0101;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.count !== 3'd3 || bus.grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL early_pre: got cnt=%0d grant=%b want 3/0001", bus.count, bus.grant);
    end
    bus.req = 4'b0100;
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.slot_done !== 1'b0 || bus.count !== 3'd0 || bus.cnt_en !== 1'b0) begin
      n_bad++;
      $display("FAIL early_release: got grant=%b done=%b cnt=%0d en=%b want 0000/0/0/0",
               bus.grant, bus.slot_done, bus.count, bus.cnt_en);
    end
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0100 || bus.count !== 3'd0 || bus.cnt_en !== 1'b1) begin
      n_bad++;
      $display("FAIL early_next: got grant=%b cnt=%0d en=%b want 0100/0/1",
               bus.grant, bus.count, bus.cnt_en);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    $display("test_early_release done");
  endtask

  task automatic test_nonowner_pulse();
    do_reset();
    bus.req = 4'b0001;
    tick();
    tick();
    bus.req = 4'b0011;
    tick();
    bus.req = 4'b0001;
    for (int i = 2; i < 8; i++) tick();
    n_cmp++;
    if (bus.slot_done !== 1'b1 || bus.grant !== 4'b0000) begin
      n_bad++;
      $display("FAIL pulse_release: got done=%b grant=%b want 1/0000", bus.slot_done, bus.grant);
    end
    bus.req = 4'b0000;
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.cnt_en !== 1'b0) begin
      n_bad++;
      $display("FAIL pulse_no_grant: got grant=%b busy=%b en=%b want 0000/0/0",
               bus.grant, bus.busy, bus.cnt_en);
    end
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0000) begin
      n_bad++;
      $display("FAIL pulse_stay_idle: got grant=%b want 0000", bus.grant);
    end
    $display("test_nonowner_pulse done");
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    bus.req = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (bus.count !== 3'd5) begin
      n_bad++;
      $display("FAIL midrst_pre: got cnt=%0d want 5", bus.count);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.grant !== 4'b0000 || bus.cnt_en !== 1'b0 || bus.count !== 3'd0 ||
        bus.busy !== 1'b0 || bus.slot_done !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: got grant=%b en=%b cnt=%0d busy=%b done=%b want all 0",
               bus.grant, bus.cnt_en, bus.count, bus.busy, bus.slot_done);
    end
    bus.req = 4'b0011;
    @(posedge clk);
    #2 reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.grant !== 4'b0001 || bus.count !== 3'd0) begin
      n_bad++;
      $display("FAIL midrst_first: got grant=%b cnt=%0d want 0001/0", bus.grant, bus.count);
    end
    bus.req = 4'b0000;
    tick();
    tick();
    $display("test_reset_mid_slot done");
  endtask

  task automatic test_slot3();
    logic [3:0] exp_g;
    do_reset();
    bus3.req = 4'b0011;
    tick();
    for (int s = 0; s < 4; s++) begin
      exp_g = (s % 2 == 0) ? 4'b0001 : 4'b0010;
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (bus3.grant !== exp_g || bus3.cnt_en !== 1'b1 || bus3.count !== 3'(i)) begin
          n_bad++;
          $display("FAIL slot3[%0d][%0d]: got grant=%b en=%b cnt=%0d want %b/1/%0d",
                   s, i, bus3.grant, bus3.cnt_en, bus3.count, exp_g, i);
        end
        tick();
      end
      n_cmp++;
      if (bus3.cnt_en !== 1'b0 || bus3.slot_done !== 1'b1 || bus3.grant !== 4'b0000) begin
        n_bad++;
        $display("FAIL slot3_gap[%0d]: got en=%b done=%b grant=%b want 0/1/0000",
                 s, bus3.cnt_en, bus3.slot_done, bus3.grant);
      end
      tick();
    end
    bus3.req = 4'b0000;
    tick();
    tick();
    $display("test_slot3 done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_early_release();
    test_nonowner_pulse();
    test_reset_mid_slot();
    test_slot3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
